// File: rtl/sop_shared_pkg.sv
// Shared definitions for the shared-product SOP engine.
//   cfg_state_e : configuration FSM states (UNCONFIG, LOADING, ACTIVE)
//   cfg_width() : length of the serial configuration vector
package sop_shared_pkg;

  typedef enum logic [1:0] {
    ST_UNCONFIG = 2'd0,
    ST_LOADING  = 2'd1,
    ST_ACTIVE   = 2'd2
  } cfg_state_e;

  // Layout, LSB first: use[PIT][N_IN], pol[PIT][N_IN], sel[N_OUT][PIT], oen[N_OUT]
  function automatic int cfg_width(input int n_in, input int n_out, input int pit);
    return 2 * pit * n_in + n_out * pit + n_out;
  endfunction

endpackage

// File: rtl/sop_shared_engine_if.sv
// Bundle of the configuration, input and output handshakes of sop_shared_engine.
//   master : stimulus / scoring side (drives cfg_*, in_*, out_ready)
//   slave  : the engine
interface sop_shared_engine_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_bit;
  logic             cfg_err;
  logic             cfg_done;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;
  logic [N_OUT:0]   err_max;
  logic             err_exceed;

  modport master (
    output cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_err, cfg_done, in_ready, out_valid, out_data, err_max, err_exceed
  );

  modport slave (
    input  cfg_valid, cfg_bit, in_valid, in_data, out_ready,
    output cfg_ready, cfg_err, cfg_done, in_ready, out_valid, out_data, err_max, err_exceed
  );
endinterface

// File: rtl/sop_cfg_loader.sv
// Serial configuration loader: shifts config bits LSB first into a shadow
// register, checks the literals-per-product limit on the final bit and copies
// the shadow into the active configuration only when the check passes.
//   clk, rst      : clock, asynchronous active-high reset
//   cfg_valid_i   : config bit offered (always accepted)
//   cfg_bit_i     : serial config bit
//   cfg_ready_o   : constant 1
//   cfg_err_o     : last commit exceeded LPP; cleared by the next accepted bit
//   cfg_done_o    : high while ACTIVE
//   active_cfg_o  : committed configuration vector
module sop_cfg_loader
  import sop_shared_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int PIT   = 2,
  parameter int LPP   = 4,
  localparam int CFG_W = cfg_width(N_IN, N_OUT, PIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  input  logic             cfg_bit_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic             cfg_done_o,
  output logic [CFG_W-1:0] active_cfg_o
);

  localparam int CNT_W = $clog2(CFG_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic             err_q, err_d;
  logic [CFG_W-1:0] shifted;
  logic             lpp_ok;

  // New bit enters at the top so that after CFG_W bits the first one sits at bit 0.
  assign shifted = {cfg_bit_i, shadow_q[CFG_W-1:1]};

  // The check looks at the vector as it will be after the committing bit.
  always_comb begin
    lpp_ok = 1'b1;
    for (int p = 0; p < PIT; p++) begin
      if ($countones(shifted[p*N_IN +: N_IN]) > LPP) lpp_ok = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    if (cfg_valid_i) begin
      shadow_d = shifted;
      err_d    = 1'b0;
      if (state_q == ST_LOADING) begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (lpp_ok) begin
            active_d = shifted;
            state_d  = ST_ACTIVE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_UNCONFIG;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // First bit of a new load: it is bit 0, so the counter restarts at 1.
        state_d = ST_LOADING;
        cnt_d   = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the config registers are reset too, so a fresh engine never evaluates stale products.
      state_q  <= ST_UNCONFIG;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready_o  = 1'b1;
  assign cfg_err_o    = err_q;
  assign cfg_done_o   = (state_q == ST_ACTIVE);
  assign active_cfg_o = active_q;

endmodule

// File: rtl/sop_shared_engine.sv
// Runtime-reconfigurable shared-product SOP evaluator with a 2-stage
// valid/ready datapath and an optional approximation-error monitor.
//   clk, rst : clock, asynchronous active-high reset
//   bus_if   : sop_shared_engine_if.slave (config, input and output handshakes,
//              err_max / err_exceed)
// Optional feature: define SOP_ERR_MON_EN to build the error monitor;
// otherwise err_max and err_exceed are tied to 0.
module sop_shared_engine
  import sop_shared_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int PIT   = 2,
  parameter int LPP   = 4,
  parameter int ET    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sop_shared_engine_if.slave   bus_if
);

  localparam int CFG_W   = cfg_width(N_IN, N_OUT, PIT);
  localparam int POL_OFS = PIT * N_IN;
  localparam int SEL_OFS = 2 * PIT * N_IN;
  localparam int OEN_OFS = SEL_OFS + N_OUT * PIT;
  localparam logic [N_OUT:0] ET_W = (N_OUT + 1)'(ET);

  logic [CFG_W-1:0] cfg;
  logic             cfg_done;

  sop_cfg_loader #(.N_IN(N_IN), .N_OUT(N_OUT), .PIT(PIT), .LPP(LPP)) u_loader (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid_i  (bus_if.cfg_valid),
    .cfg_bit_i    (bus_if.cfg_bit),
    .cfg_ready_o  (bus_if.cfg_ready),
    .cfg_err_o    (bus_if.cfg_err),
    .cfg_done_o   (cfg_done),
    .active_cfg_o (cfg)
  );
  assign bus_if.cfg_done = cfg_done;

  // Products and per-output product masks from the active config.
  logic [PIT-1:0]            prod;
  logic [N_OUT-1:0][PIT-1:0] mask;

  always_comb begin
    for (int p = 0; p < PIT; p++) begin
      // Unused literals are forced true; an empty product is forced false.
      prod[p] = (|cfg[p*N_IN +: N_IN]) &
                (&((bus_if.in_data ^ cfg[POL_OFS + p*N_IN +: N_IN]) | ~cfg[p*N_IN +: N_IN]));
    end
    for (int k = 0; k < N_OUT; k++) begin
      mask[k] = cfg[SEL_OFS + k*PIT +: PIT] & {PIT{cfg[OEN_OFS + k]}};
    end
  end

  // Handshake: a stage advances when it is empty or its successor advances.
  logic s1_valid_q, out_valid_q;
  logic s1_adv, s2_adv, in_ready, in_fire;

  assign s2_adv   = !out_valid_q || bus_if.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = cfg_done && s1_adv;
  assign in_fire  = bus_if.in_valid && in_ready;

  // The masks travel with the products so a word finishes under the config it
  // entered with, even if a new config commits while it is stalled.
  logic [PIT-1:0]            s1_prod_q;
  logic [N_OUT-1:0][PIT-1:0] s1_mask_q;
  logic [N_OUT-1:0]          out_d, out_data_q;

  always_comb begin
    for (int k = 0; k < N_OUT; k++) out_d[k] = |(s1_mask_q[k] & s1_prod_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_mask_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_fire;
        if (in_fire) begin
          s1_prod_q <= prod;
          s1_mask_q <= mask;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_data_q <= out_d;
      end
    end
  end

  assign bus_if.in_ready  = in_ready;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;

`ifdef SOP_ERR_MON_EN
  // Exact adder result travels alongside the products; the error is taken
  // against it in S2 and folded into the statistics when the result leaves.
  logic [N_OUT-1:0] exact_d, s1_exact_q, err_d, s2_err_q;
  logic [N_OUT:0]   err_max_q;
  logic             err_exceed_q;

  assign exact_d = N_OUT'(bus_if.in_data[N_IN/2-1:0]) + N_OUT'(bus_if.in_data[N_IN-1:N_IN/2]);
  assign err_d   = (out_d >= s1_exact_q) ? (out_d - s1_exact_q) : (s1_exact_q - out_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_exact_q   <= '0;
      s2_err_q     <= '0;
      err_max_q    <= '0;
      err_exceed_q <= 1'b0;
    end else begin
      if (s1_adv && in_fire)     s1_exact_q <= exact_d;
      if (s2_adv && s1_valid_q)  s2_err_q   <= err_d;
      if (out_valid_q && bus_if.out_ready) begin
        if ({1'b0, s2_err_q} > err_max_q) err_max_q <= {1'b0, s2_err_q};
        if ({1'b0, s2_err_q} > ET_W)      err_exceed_q <= 1'b1;
      end
    end
  end

  assign bus_if.err_max    = err_max_q;
  assign bus_if.err_exceed = err_exceed_q;
`else
  logic unused_et;
  assign unused_et         = ^ET_W;
  assign bus_if.err_max    = '0;
  assign bus_if.err_exceed = 1'b0;
`endif

endmodule

// File: tb/tb_sop_shared_engine.sv
// Self-checking bench for sop_shared_engine. Two engines share one stimulus
// stream: dut_a uses the default parameters, dut_b uses LPP=3 and ET=2, so the
// commit-rejection and threshold cases are visible side by side. A reference
// model evaluates the SOP from the configuration fields directly.
module tb_sop_shared_engine;

  localparam int CFG_W = 25;
  localparam int LPP_D [2] = '{4, 3};
  localparam int ET_D  [2] = '{4, 2};
`ifdef SOP_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0, cfg_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_data = '0;

  always #5 clk = ~clk;

  sop_shared_engine_if #(.N_IN(4), .N_OUT(3)) if_a ();
  sop_shared_engine_if #(.N_IN(4), .N_OUT(3)) if_b ();

  assign if_a.cfg_valid = cfg_valid;  assign if_b.cfg_valid = cfg_valid;
  assign if_a.cfg_bit   = cfg_bit;    assign if_b.cfg_bit   = cfg_bit;
  assign if_a.in_valid  = in_valid;   assign if_b.in_valid  = in_valid;
  assign if_a.in_data   = in_data;    assign if_b.in_data   = in_data;
  assign if_a.out_ready = out_ready;  assign if_b.out_ready = out_ready;

  sop_shared_engine #(.N_IN(4), .N_OUT(3), .PIT(2), .LPP(4), .ET(4)) dut_a (
    .clk(clk), .rst(rst), .bus_if(if_a));
  sop_shared_engine #(.N_IN(4), .N_OUT(3), .PIT(2), .LPP(3), .ET(2)) dut_b (
    .clk(clk), .rst(rst), .bus_if(if_b));

  logic       in_rdy [2], out_vld [2], cfg_done [2], cfg_err [2], cfg_rdy [2], err_exc [2];
  logic [2:0] out_dat [2];
  logic [3:0] err_max [2];

  assign in_rdy[0]   = if_a.in_ready;   assign in_rdy[1]   = if_b.in_ready;
  assign out_vld[0]  = if_a.out_valid;  assign out_vld[1]  = if_b.out_valid;
  assign out_dat[0]  = if_a.out_data;   assign out_dat[1]  = if_b.out_data;
  assign cfg_done[0] = if_a.cfg_done;   assign cfg_done[1] = if_b.cfg_done;
  assign cfg_err[0]  = if_a.cfg_err;    assign cfg_err[1]  = if_b.cfg_err;
  assign cfg_rdy[0]  = if_a.cfg_ready;  assign cfg_rdy[1]  = if_b.cfg_ready;
  assign err_max[0]  = if_a.err_max;    assign err_max[1]  = if_b.err_max;
  assign err_exc[0]  = if_a.err_exceed; assign err_exc[1]  = if_b.err_exceed;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] out;
    int         err;
  } exp_t;

  logic [CFG_W-1:0] m_cfg  [2];
  logic             m_done [2], m_err [2], m_exc [2];
  int               m_emax [2];
  exp_t             exp_q  [2][$];
  exp_t             sb_e;

  function automatic logic [CFG_W-1:0] mk_cfg(
    input logic [3:0] u0, input logic [3:0] p0, input logic [3:0] u1, input logic [3:0] p1,
    input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2, input logic [2:0] oen);
    return {oen, s2, s1, s0, p1, p0, u1, u0};
  endfunction

  // Field offsets: use 0..7, pol 8..15, sel 16..21, oen 22..24.
  function automatic logic [2:0] ref_out(input logic [CFG_W-1:0] c, input logic [3:0] x);
    logic [2:0] o;
    bit         any_lit, all_true;
    o = '0;
    for (int k = 0; k < 3; k++) begin
      if (c[22 + k]) begin
        for (int p = 0; p < 2; p++) begin
          if (c[16 + 2*k + p]) begin
            any_lit  = 1'b0;
            all_true = 1'b1;
            for (int i = 0; i < 4; i++) begin
              if (c[4*p + i]) begin
                any_lit = 1'b1;
                if ((x[i] ^ c[8 + 4*p + i]) == 1'b0) all_true = 1'b0;
              end
            end
            if (any_lit && all_true) o[k] = 1'b1;
          end
        end
      end
    end
    return o;
  endfunction

  function automatic int ref_err(input logic [2:0] o, input logic [3:0] x);
    int exact, diff;
    exact = int'(x[1:0]) + int'(x[3:2]);
    diff  = int'(o) - exact;
    return (diff < 0) ? -diff : diff;
  endfunction

  function automatic bit lpp_ok(input logic [CFG_W-1:0] c, input int lpp);
    for (int p = 0; p < 2; p++) begin
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) if (c[4*p + i]) n++;
      if (n > lpp) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Scoreboard: sampled on the falling edge, where all signals are settled.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cfg_ready%0d", d), cfg_rdy[d], 1'b1);
        chk($sformatf("cfg_done%0d", d), cfg_done[d], m_done[d]);
        chk($sformatf("cfg_err%0d", d), cfg_err[d], m_err[d]);
        chk($sformatf("err_max%0d", d), err_max[d], m_emax[d]);
        chk($sformatf("err_exceed%0d", d), err_exc[d], m_exc[d]);
        if (out_vld[d]) begin
          chk($sformatf("out_expected%0d", d), exp_q[d].size() != 0, 1'b1);
          if (exp_q[d].size() != 0) begin
            chk($sformatf("out_data%0d", d), out_dat[d], exp_q[d][0].out);
            if (out_ready) begin
              sb_e = exp_q[d].pop_front();
              if (MON) begin
                if (sb_e.err > m_emax[d]) m_emax[d] = sb_e.err;
                if (sb_e.err > ET_D[d])   m_exc[d]  = 1'b1;
              end
            end
          end
        end
        if (in_valid && in_rdy[d]) begin
          sb_e.out = ref_out(m_cfg[d], in_data);
          sb_e.err = ref_err(sb_e.out, in_data);
          exp_q[d].push_back(sb_e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_cfg[d] = '0; m_done[d] = 1'b0; m_err[d] = 1'b0; m_exc[d] = 1'b0; m_emax[d] = 0;
      exp_q[d].delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cycle_in(input logic [3:0] d, output logic acc);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    acc = in_rdy[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_load(input logic [CFG_W-1:0] v, input int nbits, input bit hold_in);
    for (int i = 0; i < nbits; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = v[i];
      if (hold_in) begin
        in_valid = 1'b1;
        in_data  = 4'($urandom);
      end
      @(posedge clk); #1;
      if (i == 0) for (int d = 0; d < 2; d++) begin m_done[d] = 1'b0; m_err[d] = 1'b0; end
      if (i == CFG_W - 1) begin
        for (int d = 0; d < 2; d++) begin
          if (lpp_ok(v, LPP_D[d])) begin m_cfg[d] = v; m_done[d] = 1'b1; end
          else m_err[d] = 1'b1;
        end
      end
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 30 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); n++) idle(1);
    chk("drain_a", exp_q[0].size(), 0);
    chk("drain_b", exp_q[1].size(), 0);
  endtask

  task automatic chk_reset(input string ph);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_out_valid%0d", ph, d), out_vld[d], 1'b0);
      chk($sformatf("%s_out_data%0d", ph, d), out_dat[d], 3'b000);
      chk($sformatf("%s_cfg_done%0d", ph, d), cfg_done[d], 1'b0);
      chk($sformatf("%s_in_ready%0d", ph, d), in_rdy[d], 1'b0);
      chk($sformatf("%s_cfg_err%0d", ph, d), cfg_err[d], 1'b0);
      chk($sformatf("%s_err_max%0d", ph, d), err_max[d], 4'd0);
      chk($sformatf("%s_err_exceed%0d", ph, d), err_exc[d], 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [CFG_W-1:0] tc, bc, rc;
    logic [3:0]       words [4];
    logic             acc;
    int               idx;

    model_clear();
    tc = mk_cfg(4'b0010, 4'b0000, 4'b0011, 4'b0010, 2'b00, 2'b01, 2'b11, 3'b110);
    bc = mk_cfg(4'b1111, 4'b0000, 4'b0011, 4'b0010, 2'b00, 2'b01, 2'b11, 3'b110);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("por");

    // Load the test config and check latency of the first word.
    cfg_load(tc, CFG_W, 1'b0);
    chk("loaded_done_a", cfg_done[0], 1'b1);
    chk("loaded_done_b", cfg_done[1], 1'b1);
    cycle_in(4'b0011, acc);
    chk("acc_0011", acc, 1'b1);
    chk("lat1_out_valid", out_vld[0], 1'b0);
    idle(1);
    chk("lat2_out_valid", out_vld[0], 1'b1);
    chk("lat2_out_0011", out_dat[0], 3'b110);
    idle(1);
    chk("errmax_after_0011", err_max[0], MON ? 4'd3 : 4'd0);
    chk("exceed_a_et4", err_exc[0], 1'b0);
    chk("exceed_b_et2", err_exc[1], MON);

    // Back-to-back words at full throughput.
    cycle_in(4'b0001, acc);
    cycle_in(4'b1111, acc);
    chk("out_0001", out_dat[0], 3'b100);
    idle(1);
    chk("out_1111", out_dat[0], 3'b110);
    idle(2);
    chk("errmax_stays_3", err_max[0], MON ? 4'd3 : 4'd0);
    chk("exceed_b_sticky", err_exc[1], MON);

    // Product 0 with four literals: accepted by dut_a, rejected by dut_b (LPP=3).
    cfg_load(bc, CFG_W, 1'b0);
    chk("lpp_err_b", cfg_err[1], 1'b1);
    chk("lpp_done_b", cfg_done[1], 1'b0);
    chk("lpp_in_ready_b", in_rdy[1], 1'b0);
    chk("lpp_err_a", cfg_err[0], 1'b0);
    chk("lpp_done_a", cfg_done[0], 1'b1);

    // Reload with in_valid held high, including the commit cycle.
    cfg_load(tc, CFG_W, 1'b1);
    drain();
    chk("reload_err_b", cfg_err[1], 1'b0);
    chk("reload_done_b", cfg_done[1], 1'b1);

    // Backpressure: four words against a stalled output for five cycles.
    for (int i = 0; i < 4; i++) words[i] = 4'($urandom);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin
        cycle_in(words[idx], acc);
        if (acc) idx++;
      end
    end
    chk("bp_words_held", idx, 2);
    chk("bp_in_ready", in_rdy[0], 1'b0);
    chk("bp_out_valid", out_vld[0], 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      cycle_in(words[idx], acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 4);
    drain();

    // Reset mid-pipe and mid-load (after bit 10).
    out_ready = 1'b0;
    cycle_in(4'b0011, acc);
    cfg_load(tc, 10, 1'b0);
    rst = 1'b1;
    #2;
    chk_reset("midload");
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cfg_load(tc, CFG_W, 1'b0);
    cycle_in(4'b0011, acc);
    cycle_in(4'b0001, acc);
    cycle_in(4'b1111, acc);
    drain();
    chk("post_reset_errmax", err_max[0], MON ? 4'd3 : 4'd0);

    // Random configurations and traffic with random backpressure.
    for (int r = 0; r < 4; r++) begin
      rc = CFG_W'($urandom);
      cfg_load(rc, CFG_W, bit'($urandom_range(0, 1)));
      for (int c = 0; c < 40; c++) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 4'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
